// File: rtl/dlx_data_mem_bridge_if.sv
// rtl/dlx_data_mem_bridge_if.sv - core data port plus TX/RX stream signals of the data bridge
interface dlx_data_mem_bridge_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32
);
    logic                       data_rd_en;
    logic                       data_wr_en;
    logic [DATA_ADDR_WIDTH-1:0] data_addr;
    logic [DATA_WIDTH-1:0]      data_write;
    logic [DATA_WIDTH-1:0]      data_read;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH-1:0]      out_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       err_pulse;

    modport master (
        output data_rd_en, data_wr_en, data_addr, data_write, out_ready, in_valid, in_data,
        input  data_read, out_valid, out_data, in_ready, err_pulse
    );

    modport slave (
        input  data_rd_en, data_wr_en, data_addr, data_write, out_ready, in_valid, in_data,
        output data_read, out_valid, out_data, in_ready, err_pulse
    );
endinterface

// File: rtl/dlx_data_mem_bridge.sv
// rtl/dlx_data_mem_bridge.sv - uDLX data-port decoder: local RAM, MMIO TX FIFO / RX register, error flag
module dlx_data_mem_bridge #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          DATA_ADDR_WIDTH = 32,
    parameter int          RAM_ADDR_WIDTH  = 10,
    parameter int          FIFO_AW         = 2,
    parameter logic [31:0] MMIO_BASE       = 32'hFFFF0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dlx_data_mem_bridge_if.slave bus
);
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem  [0:RAM_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_fifo [0:FIFO_DEPTH-1];
    logic [FIFO_AW-1:0]    r_wptr;
    logic [FIFO_AW-1:0]    r_rptr;
    logic [FIFO_AW:0]      r_count;
    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [DATA_WIDTH-1:0] r_data_read;
    logic                  r_err;

    logic                      w_is_ram;
    logic                      w_is_mmio;
    logic                      w_unmapped;
    logic                      w_dual;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
    logic [1:0]                w_off;
    logic                      w_tx_full;
    logic                      w_tx_empty;
    logic                      w_tx_wr;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_overflow;
    logic                      w_rx_rd;
    logic                      w_rx_take;
    logic [DATA_WIDTH-1:0]     w_status;
    logic [DATA_WIDTH-1:0]     w_rdata;
    logic                      w_unused;

    assign w_unused   = ^bus.data_addr[1:0];
    assign w_is_ram   = (bus.data_addr[DATA_ADDR_WIDTH-1:RAM_ADDR_WIDTH+2] == '0);
    assign w_is_mmio  = (bus.data_addr[31:16] == MMIO_BASE[31:16]);
    assign w_unmapped = (bus.data_rd_en | bus.data_wr_en) & ~w_is_ram & ~w_is_mmio;
    assign w_dual     = bus.data_rd_en & bus.data_wr_en;
    assign w_ram_idx  = bus.data_addr[RAM_ADDR_WIDTH+1:2];
    assign w_off      = bus.data_addr[3:2];

    // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push into a full FIFO.
    assign w_tx_full  = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign w_tx_empty = (r_count == '0);
    assign w_tx_wr    = bus.data_wr_en & w_is_mmio & (w_off == 2'd0);
    assign w_push     = w_tx_wr & ~w_tx_full;
    assign w_overflow = w_tx_wr & w_tx_full;
    assign w_pop      = ~w_tx_empty & bus.out_ready;

    assign w_rx_rd    = bus.data_rd_en & ~bus.data_wr_en & w_is_mmio & (w_off == 2'd2);
    assign w_rx_take  = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = ~r_rx_valid & ~rst_n;
    assign bus.out_valid = ~w_tx_empty;
    assign bus.out_data  = w_tx_empty ? '0 : r_fifo[r_rptr];
    assign bus.data_read = r_data_read;
    assign bus.err_pulse = r_err;

    always_comb begin
        w_status                  = '0;
        w_status[0]               = w_tx_full;
        w_status[1]               = w_tx_empty;
        w_status[2]               = r_rx_valid;
        w_status[4 +: FIFO_AW+1]  = r_count;
    end

    always_comb begin
        w_rdata = '0;
        if (!w_dual && !w_unmapped) begin
            if (w_is_ram) begin
                w_rdata = r_mem[w_ram_idx];
            end else begin
                case (w_off)
                    2'd1:    w_rdata = w_status;
                    2'd2:    w_rdata = r_rx_valid ? r_rx_data : '0;
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_data_read <= '0;
            r_err       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
        end else begin
            r_err <= w_unmapped | w_dual | w_overflow;
            if (bus.data_rd_en) begin
                r_data_read <= w_rdata;
            end
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // in_ready is low whenever rx_valid is set, so capture and RXDATA read never collide.
            if (w_rx_take) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= bus.in_data;
            end else if (w_rx_rd) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // Storage arrays carry no reset; RAM contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (!rst_n && w_push) begin
            r_fifo[r_wptr] <= bus.data_write;
        end
        if (!rst_n && bus.data_wr_en && w_is_ram) begin
            r_mem[w_ram_idx] <= bus.data_write;
        end
    end
endmodule

// File: tb/tb_dlx_data_mem_bridge.sv
// tb/tb_dlx_data_mem_bridge.sv - self-checking bench for dlx_data_mem_bridge
module tb_dlx_data_mem_bridge;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dlx_data_mem_bridge_if bus ();
    dlx_data_mem_bridge dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: sparse RAM, FIFO as a queue, RX as a valid/data pair.
    logic [31:0] m_ram [int];
    logic [31:0] m_fifo [$];
    logic        m_rx_valid;
    logic [31:0] m_rx_data;
    logic [31:0] m_dr;
    bit          m_dr_known;
    logic        m_err;

    localparam logic [31:0] TX = 32'hFFFF0000;
    localparam logic [31:0] ST = 32'hFFFF0004;
    localparam logic [31:0] RX = 32'hFFFF0008;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_dr;
        logic        exp_err;
    } vec_t;
    vec_t vt [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = 32'h0;
        s[0]   = (m_fifo.size() == 4);
        s[1]   = (m_fifo.size() == 0);
        s[2]   = m_rx_valid;
        s[6:4] = 3'(m_fifo.size());
        return s;
    endfunction

    task automatic model_step();
        logic [31:0] a;
        logic [31:0] st;
        logic        rd, wr, ram, mmio, unm, full, rxv_pre;
        int          off, idx;
        a  = bus.data_addr;
        rd = bus.data_rd_en;
        wr = bus.data_wr_en;
        if (rst_n) begin
            m_fifo.delete();
            m_rx_valid = 1'b0;
            m_dr       = 32'h0;
            m_dr_known = 1'b1;
            m_err      = 1'b0;
            return;
        end
        ram     = (a < 32'd4096);
        mmio    = (a[31:16] == 16'hFFFF);
        unm     = (rd || wr) && !ram && !mmio;
        off     = int'(a[3:2]);
        idx     = int'(a[11:2]);
        st      = m_status();
        full    = (m_fifo.size() == 4);
        rxv_pre = m_rx_valid;
        m_err   = unm || (rd && wr) || (wr && mmio && off == 0 && full);
        if (rd) begin
            m_dr_known = 1'b1;
            if (wr || unm) m_dr = 32'h0;
            else if (ram) begin
                if (m_ram.exists(idx)) m_dr = m_ram[idx];
                else m_dr_known = 1'b0;
            end
            else if (off == 1) m_dr = st;
            else if (off == 2) begin
                m_dr       = rxv_pre ? m_rx_data : 32'h0;
                m_rx_valid = 1'b0;
            end
            else m_dr = 32'h0;
        end
        if (m_fifo.size() > 0 && bus.out_ready) void'(m_fifo.pop_front());
        if (wr && mmio && off == 0 && !full) m_fifo.push_back(bus.data_write);
        if (wr && ram) m_ram[idx] = bus.data_write;
        if (bus.in_valid && !rxv_pre) begin
            m_rx_valid = 1'b1;
            m_rx_data  = bus.in_data;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        if (m_dr_known) check("data_read", bus.data_read, m_dr);
        check("err_pulse", bus.err_pulse, m_err);
        check("out_valid", bus.out_valid, m_fifo.size() > 0);
        check("out_data", bus.out_data, (m_fifo.size() > 0) ? m_fifo[0] : 32'h0);
        check("in_ready", bus.in_ready, !m_rx_valid && !rst_n);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        bus.data_rd_en = rd;
        bus.data_wr_en = wr;
        bus.data_addr  = addr;
        bus.data_write = wd;
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b1, 32'h0,        32'h11111111, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
        vt[2]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 32'h13,       32'h0,        32'hDEADBEEF, 1'b0};
        vt[4]  = '{1'b0, 1'b1, TX,           32'd1,        32'hDEADBEEF, 1'b0};
        vt[5]  = '{1'b0, 1'b1, TX,           32'd2,        32'hDEADBEEF, 1'b0};
        vt[6]  = '{1'b0, 1'b1, TX,           32'd3,        32'hDEADBEEF, 1'b0};
        vt[7]  = '{1'b0, 1'b1, TX,           32'd4,        32'hDEADBEEF, 1'b0};
        vt[8]  = '{1'b0, 1'b1, TX,           32'd5,        32'hDEADBEEF, 1'b1};
        vt[9]  = '{1'b1, 1'b0, ST,           32'h0,        32'h41,       1'b0};
        vt[10] = '{1'b1, 1'b0, 32'hFFFF000C, 32'h0,        32'h0,        1'b0};
        vt[11] = '{1'b0, 1'b1, 32'h80000000, 32'h99,       32'h0,        1'b1};
        vt[12] = '{1'b1, 1'b0, 32'h80000000, 32'h0,        32'h0,        1'b1};
        vt[13] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h11111111, 1'b0};
        vt[14] = '{1'b1, 1'b1, 32'h20,       32'hCAFEF00D, 32'h0,        1'b1};
        vt[15] = '{1'b1, 1'b0, 32'h20,       32'h0,        32'hCAFEF00D, 1'b0};
        vt[16] = '{1'b0, 1'b1, ST,           32'hFF,       32'hCAFEF00D, 1'b0};
        vt[17] = '{1'b1, 1'b0, ST,           32'h0,        32'h41,       1'b0};
        vt[18] = '{1'b1, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1};
        vt[19] = '{1'b1, 1'b0, RX,           32'h0,        32'h0,        1'b0};

        m_rx_valid = 1'b0;
        m_rx_data  = 32'h0;
        m_dr       = 32'h0;
        m_dr_known = 1'b0;
        m_err      = 1'b0;
        rst_n         = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        cycle();
        check("reset_data_read", bus.data_read, 32'h0);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out_data", bus.out_data, 32'h0);
        check("reset_in_ready", bus.in_ready, 1'b0);
        check("reset_err", bus.err_pulse, 1'b0);
        rst_n = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata);
            cycle();
            check($sformatf("vec%0d_dr", i), bus.data_read, vt[i].exp_dr);
            check($sformatf("vec%0d_err", i), bus.err_pulse, vt[i].exp_err);
        end

        // Drain the full FIFO in order.
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_head%0d", k), bus.out_data, 32'(k));
            cycle();
        end
        check("drain_valid_low", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, ST, 32'h0);
        cycle();
        check("status_drained", bus.data_read, 32'h02);

        // Steady state at two entries with a push and a pop every cycle.
        drive(1'b0, 1'b1, TX, 32'hA0);
        check("nobypass_before", bus.out_valid, 1'b0);
        cycle();
        check("nobypass_after", bus.out_valid, 1'b1);
        drive(1'b0, 1'b1, TX, 32'hA1);
        cycle();
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("steady_head%0d", k), bus.out_data, 32'hA0 + 32'(k - 2));
            drive(1'b0, 1'b1, TX, 32'hA0 + 32'(k));
            cycle();
        end
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, ST, 32'h0);
        cycle();
        check("status_steady", bus.data_read, 32'h20);

        // RX holding register: capture, hold off a second word, read-clear.
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234;
        check("rx_ready_before", bus.in_ready, 1'b1);
        cycle();
        check("rx_ready_after", bus.in_ready, 1'b0);
        bus.in_data = 32'h5555;
        drive(1'b1, 1'b0, ST, 32'h0);
        cycle();
        check("status_rx", bus.data_read, 32'h24);
        drive(1'b1, 1'b0, RX, 32'h0);
        cycle();
        check("rx_data", bus.data_read, 32'h1234);
        check("rx_ready_back", bus.in_ready, 1'b1);
        cycle();
        bus.in_valid = 1'b0;
        drive(1'b1, 1'b0, RX, 32'h0);
        cycle();
        check("rx_data2", bus.data_read, 32'h5555);

        // Reset with three queued entries and a read in flight.
        drive(1'b0, 1'b1, TX, 32'hB0);
        cycle();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        cycle();
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_data_read", bus.data_read, 32'h0);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, ST, 32'h0);
        cycle();
        check("midrst_status", bus.data_read, 32'h02);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        cycle();
        check("midrst_ram", bus.data_read, 32'hDEADBEEF);

        // Randomized traffic against the model.
        for (int w = 0; w < 16; w++) begin
            drive(1'b0, 1'b1, 32'(w * 4), $urandom);
            cycle();
        end
        for (int w = 1020; w < 1024; w++) begin
            drive(1'b0, 1'b1, 32'(w * 4), $urandom);
            cycle();
        end
        for (int n = 0; n < 500; n++) begin
            int          sel, op, idx;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            op  = int'($urandom_range(0, 7));
            if (sel < 4) begin
                idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1020, 1023));
                a   = 32'(idx * 4) + 32'($urandom_range(0, 3));
            end else if (sel < 8) begin
                a = TX + 32'($urandom_range(0, 3) * 4);
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h00001000;
                    1:       a = 32'h80000000;
                    default: a = 32'hFFFE0000;
                endcase
            end
            drive(op < 3 || op == 6, (op >= 3 && op <= 6), a, $urandom);
            bus.out_ready = $urandom_range(0, 1) == 1;
            bus.in_valid  = $urandom_range(0, 2) == 0;
            bus.in_data   = $urandom;
            rst_n         = $urandom_range(0, 63) == 0;
            cycle();
        end

        rst_n = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dlx_data_mem_bridge.md
Name: dlx_data_mem_bridge

Overview:
- Sits directly downstream of the uDLX core's data port. Consumes data_rd_en, data_wr_en, data_addr and data_write, and produces data_read for the write-back stage.
- Decodes each access to one of three targets: a local synchronous data RAM, a small MMIO block, or an unmapped region.
- The MMIO block contains a posted TX FIFO with a valid/ready output stream and a one-entry RX holding register with a valid/ready input stream.
- The core has no data-side stall, so every read returns data exactly one cycle after data_rd_en.

Parameters:
- DATA_WIDTH, 32, data word width.
- DATA_ADDR_WIDTH, 32, byte address width from the core.
- RAM_ADDR_WIDTH, 10, log2 of RAM depth in words (1024 words, 4 KiB).
- FIFO_AW, 2, log2 of TX FIFO depth (4 entries).
- MMIO_BASE, 32'hFFFF0000, MMIO window base; decode uses bits [31:16].

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset. Synchronous and active-high: 1 = reset, despite the name.
- data_rd_en  in  1  load request from the core.
- data_wr_en  in  1  store request from the core.
- data_addr  in  DATA_ADDR_WIDTH  byte address; bits [1:0] are ignored.
- data_write  in  DATA_WIDTH  store data.
- data_read  out  DATA_WIDTH  load data, registered.
- out_valid  out  1  TX stream valid.
- out_ready  in  1  TX stream ready.
- out_data  out  DATA_WIDTH  TX stream data (the FIFO head).
- in_valid  in  1  RX stream valid.
- in_ready  out  1  RX stream ready.
- in_data  in  DATA_WIDTH  RX stream data.
- err_pulse  out  1  one-cycle flag marking an illegal access.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high on rst_n, sampled at the rising edge.
- Reset values:
  - data_read = 0, err_pulse = 0.
  - TX FIFO empty, so out_valid = 0 and out_data = 0.
  - RX holding register empty (rx_valid = 0); in_ready = 0 while reset is asserted.
  - RAM contents are not reset.
- Decode:
  - RAM when data_addr < 4 * 2^RAM_ADDR_WIDTH; word index = data_addr[RAM_ADDR_WIDTH+1:2].
  - MMIO when data_addr[31:16] == MMIO_BASE[31:16]; the register is selected by offset data_addr[3:2].
  - Everything else is unmapped.
- MMIO map:
  - Offset 0x0, TXDATA. A write pushes to the FIFO; a read returns 0.
  - Offset 0x4, STATUS, read-only. Bit 0 = tx_full, bit 1 = tx_empty, bit 2 = rx_valid, bits [6:4] = tx_count (0..4), all other bits 0. Writes are ignored.
  - Offset 0x8, RXDATA. A read returns the RX register and clears rx_valid at the same edge. Reading while rx_valid = 0 returns 0, with no error.
  - Offset 0xC is reserved: reads return 0, writes are ignored, no error.
- Read latency:
  - data_rd_en at edge N produces data_read valid after edge N+1, which the core samples in write-back.
  - data_read holds its value until the next read completes.
  - MMIO read values are registered the same way as RAM reads.
- Writes: RAM writes take effect at the edge where data_wr_en = 1. A read of the same address in the next cycle returns the new data.
- TX FIFO:
  - Push when TXDATA is written and the FIFO is not full. Fullness is evaluated before the same-cycle pop.
  - A write while full is dropped and raises err_pulse, even if a pop occurs in that cycle.
  - Pop when out_valid && out_ready.
  - No bypass: a push into an empty FIFO raises out_valid one cycle later.
  - Pointers wrap modulo 2^FIFO_AW. tx_count is FIFO_AW+1 bits wide and is updated for push, pop, or both (a simultaneous push and pop leaves it unchanged).
  - out_data and out_valid are stable while out_valid = 1 and out_ready = 0.
- RX path:
  - in_ready = !rx_valid && !reset.
  - A transfer occurs when in_valid && in_ready; it captures in_data and sets rx_valid.
  - A new capture is never possible in the same edge as an RXDATA read, because in_ready is low while rx_valid = 1.
- err_pulse is high for exactly one cycle, following the offending edge, in these cases:
  - Any access to the unmapped region. Writes are dropped and reads return 0.
  - data_rd_en and data_wr_en both asserted. The write is performed and the read returns 0.
  - A TXDATA write while the FIFO is full.
- Reset mid-operation: the FIFO and RX register are cleared immediately, any in-flight read result is discarded (data_read becomes 0), and RAM is untouched.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x00000010 and read 0x00000010 in the next cycle -> data_read = 0xDEADBEEF one cycle after data_rd_en. Read 0x00000013 -> same word.
- With out_ready = 0, write 1,2,3,4,5 to 0xFFFF0000:
  - STATUS reads 0x41 (count 4, full).
  - The 5th write pulses err_pulse.
  - Raising out_ready drains 1,2,3,4 in order, one per cycle; afterwards out_valid = 0 and STATUS = 0x02.
- Keep the FIFO at 2 entries with out_ready = 1 and write TXDATA every cycle -> tx_count stays 2 and out_data follows push order with no loss.
- Drive in_valid = 1, in_data = 0x1234 -> in_ready drops the next cycle and STATUS bit 2 = 1. Read 0xFFFF0008 -> data_read = 0x1234, rx_valid clears, in_ready returns to 1.
- Access 0x80000000 (read and write) and assert both enables on a RAM address -> one err_pulse per access, read data 0, RAM unchanged except for the dual-enable write.
- Assert rst_n with 3 FIFO entries and a pending read -> on the next cycle out_valid = 0, data_read = 0, STATUS = 0x02, and RAM data is preserved.
